// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg
//   Shared constants and helpers for the minimips MEM stage.
//   Holds the 4-bit memory operation codes, the FSM state encodings,
//   the NOP destination register, and small decode helpers that are used
//   by mem_lsu and mem_lane_align.
//   No ports (package).

package mem_lsu_pkg;

    // Memory operation codes carried on ex_memop.
    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    // FSM states.
    localparam logic [0:0] MEM_IDLE = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    // Register address written by bubbles / reset.
    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
               (op == MEM_OP_LHU) || (op == MEM_OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Access size as log2(bytes): 0 = byte, 1 = half, 2 = word.
    function automatic logic [1:0] size_code(input logic [3:0] op);
        logic [1:0] code;
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: code = 2'd0;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: code = 2'd1;
            default:                          code = 2'd2;
        endcase
        return code;
    endfunction

    // True when the low address bits are not on the natural boundary of the access.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic bad;
        case (size_code(op))
            2'd0:    bad = 1'b0;
            2'd1:    bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if
//   Data-bus req/ack interface between the load/store unit and memory.
//   Parameters: DATA_W (data width), ADDR_W (address width).
//   Signals:
//     req    transaction request (master -> slave)
//     we     1 = store
//     addr   word-aligned address
//     sel    byte-lane enables, DATA_W/8 bits
//     wdata  store data replicated across lanes
//     ack    transaction complete, rdata valid this cycle (slave -> master)
//     rdata  read data
//   Modports: master (load/store unit), slave (memory side).

interface mem_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   sel;
    logic [DATA_W-1:0]     wdata;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational byte-lane steering for the MEM stage.
//   Parameter: DATA_W (32 or 64).
//   Ports:
//     memop  in   4            memory operation code
//     lane   in   log2(DATA_W/8) low address bits (byte lane index)
//     mdata  in   DATA_W       store data (rt)
//     rdata  in   DATA_W       bus read data
//     sel    out  DATA_W/8     byte-lane enables
//     wdata  out  DATA_W       store data replicated across all lanes
//     ldata  out  DATA_W       extracted and sign/zero-extended load data
//   Address bits below the access size are dropped, so the lane used is
//   always the natural boundary of the access.

module mem_lane_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]                  memop,
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic [DATA_W-1:0]           mdata,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W/8-1:0]         sel,
    output logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           ldata
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] base;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] shifted;

    // Pick the first lane of the access, its lane mask and the replicated
    // store pattern, then shift the read word down so the addressed bytes
    // sit at bit 0 before extension.
    always_comb begin
        base    = lane;
        mask    = LANES'(1);
        wdata   = {LANES{mdata[7:0]}};
        ldata   = '0;
        case (size_code(memop))
            2'd0: begin
                base  = lane;
                mask  = LANES'(1);
                wdata = {LANES{mdata[7:0]}};
            end
            2'd1: begin
                base  = lane & ~LANE_W'(1);
                mask  = LANES'(3);
                wdata = {(LANES/2){mdata[15:0]}};
            end
            default: begin
                base  = lane & ~LANE_W'(3);
                mask  = LANES'(15);
                wdata = {(LANES/4){mdata[31:0]}};
            end
        endcase
        sel     = mask << base;
        shifted = rdata >> {base, 3'b000};
        case (memop)
            MEM_OP_LB:  ldata = DATA_W'($signed(shifted[7:0]));
            MEM_OP_LBU: ldata = DATA_W'(shifted[7:0]);
            MEM_OP_LH:  ldata = DATA_W'($signed(shifted[15:0]));
            MEM_OP_LHU: ldata = DATA_W'(shifted[15:0]);
            MEM_OP_LW:  ldata = DATA_W'($signed(shifted[31:0]));
            default:    ldata = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu
//   MEM stage of the minimips pipeline: registered EX/MEM -> MEM/WB with a
//   load/store unit. Pass-through ops retire in one cycle; loads and stores
//   run a req/ack transaction on the data bus, stall the pipe while waiting,
//   then retire. A wait counter aborts a transaction that never acks.
//   Optional feature macro: MEM_ALIGN_EXC_EN -- when defined, misaligned
//   half/word accesses issue no bus request and retire next cycle with a
//   bus_err pulse; when undefined, low address bits are truncated.
//   Parameters: DATA_W (32/64), ADDR_W, REG_ADDR_W, TIMEOUT (1..65535).
//   Ports:
//     clk, rst                 clock, async active-high reset
//     ex_valid/ex_wd/ex_wreg   EX/MEM slot, destination, write enable
//     ex_wdata                 ALU result for pass-through ops
//     ex_memop/ex_maddr/ex_mdata  memory op code, address, store data
//     bus                      mem_lsu_if.master data bus
//     stallreq                 hold upstream stages (high in WAIT)
//     bus_err                  one-cycle error pulse
//     wb_valid/wb_wd/wb_wreg/wb_wdata  registered MEM/WB outputs

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [3:0]            ex_memop,
    input  logic [ADDR_W-1:0]     ex_maddr,
    input  logic [DATA_W-1:0]     ex_mdata,
    mem_lsu_if.master             bus,
    output logic                  stallreq,
    output logic                  bus_err,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [DATA_W-1:0]     wb_wdata
);
    localparam int          LANE_W   = $clog2(DATA_W / 8);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [0:0]            state;
    logic [15:0]           tmo_cnt;
    logic [REG_ADDR_W-1:0] hold_wd;
    logic                  hold_wreg;
    logic [3:0]            hold_op;
    logic [LANE_W-1:0]     hold_lane;

    logic [3:0]            align_op;
    logic [LANE_W-1:0]     align_lane;
    logic [DATA_W/8-1:0]   align_sel;
    logic [DATA_W-1:0]     align_wdata;
    logic [DATA_W-1:0]     align_ldata;

    // One lane aligner serves both phases: in IDLE it shapes the outgoing
    // request from ex_*, in WAIT it extracts load data for the held op.
    assign align_op   = (state == MEM_WAIT) ? hold_op   : ex_memop;
    assign align_lane = (state == MEM_WAIT) ? hold_lane : ex_maddr[LANE_W-1:0];

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .memop (align_op),
        .lane  (align_lane),
        .mdata (ex_mdata),
        .rdata (bus.rdata),
        .sel   (align_sel),
        .wdata (align_wdata),
        .ldata (align_ldata)
    );

    assign stallreq = (state == MEM_WAIT);

    // Main FSM: IDLE accepts an instruction, WAIT holds the bus request until
    // ack or timeout. Expiry is only taken when ack is absent, so an ack on
    // the last allowed cycle still retires normally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MEM_IDLE;
            tmo_cnt   <= '0;
            hold_wd   <= '0;
            hold_wreg <= 1'b0;
            hold_op   <= MEM_OP_NONE;
            hold_lane <= '0;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.sel   <= '0;
            bus.wdata <= '0;
            bus_err   <= 1'b0;
            wb_valid  <= 1'b0;
            wb_wd     <= REG_ADDR_W'(NOP_REG_ADDR);
            wb_wreg   <= 1'b0;
            wb_wdata  <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (ex_valid && is_mem_op(ex_memop)) begin
`ifdef MEM_ALIGN_EXC_EN
                        if (is_misaligned(ex_memop, ex_maddr[1:0])) begin
                            wb_valid <= 1'b1;
                            wb_wd    <= ex_wd;
                            wb_wreg  <= 1'b0;
                            wb_wdata <= '0;
                            bus_err  <= 1'b1;
                        end else
`endif
                        begin
                            bus.req   <= 1'b1;
                            bus.we    <= is_store(ex_memop);
                            bus.addr  <= {ex_maddr[ADDR_W-1:LANE_W], LANE_W'(0)};
                            bus.sel   <= align_sel;
                            bus.wdata <= align_wdata;
                            hold_wd   <= ex_wd;
                            hold_wreg <= ex_wreg;
                            hold_op   <= ex_memop;
                            hold_lane <= ex_maddr[LANE_W-1:0];
                            tmo_cnt   <= '0;
                            state     <= MEM_WAIT;
                            wb_valid  <= 1'b0;
                            wb_wreg   <= 1'b0;
                            wb_wdata  <= '0;
                        end
                    end else if (ex_valid) begin
                        wb_valid <= 1'b1;
                        wb_wd    <= ex_wd;
                        wb_wreg  <= ex_wreg;
                        wb_wdata <= ex_wdata;
                    end else begin
                        wb_valid <= 1'b0;
                        wb_wreg  <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.ack) begin
                        state    <= MEM_IDLE;
                        bus.req  <= 1'b0;
                        bus.we   <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_wd    <= hold_wd;
                        if (is_load(hold_op)) begin
                            wb_wreg  <= hold_wreg;
                            wb_wdata <= align_ldata;
                        end else begin
                            wb_wreg  <= 1'b0;
                            wb_wdata <= '0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= MEM_IDLE;
                        bus.req  <= 1'b0;
                        bus.we   <= 1'b0;
                        bus_err  <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_wd    <= hold_wd;
                        wb_wreg  <= 1'b0;
                        wb_wdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu
//   Self-checking bench for mem_lsu (DATA_W=32, TIMEOUT=4). Directed cases
//   for pass-through, lane steering, timeout and reset, followed by random
//   instructions checked against a byte-level reference model.
//   Honours MEM_ALIGN_EXC_EN the same way as the design.

module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_mdata;
    logic        stallreq;
    logic        bus_err;
    logic        wb_valid;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_wd    (ex_wd),
        .ex_wreg  (ex_wreg),
        .ex_wdata (ex_wdata),
        .ex_memop (ex_memop),
        .ex_maddr (ex_maddr),
        .ex_mdata (ex_mdata),
        .bus      (bus),
        .stallreq (stallreq),
        .bus_err  (bus_err),
        .wb_valid (wb_valid),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model helpers: bytes per access, load/sign classification.
    function automatic int access_bytes(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
            MEM_OP_LW, MEM_OP_SW:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit op_loads(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
               (op == MEM_OP_LHU) || (op == MEM_OP_LW);
    endfunction

    function automatic bit op_signed(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW);
    endfunction

    // Drive one instruction for a cycle, play the memory side with an ack
    // after 'delay' idle WAIT cycles, and check everything against the model.
    task automatic applyStimulus(
        input  logic [3:0]  op,
        input  logic [4:0]  wd,
        input  logic        wreg,
        input  logic [31:0] alu,
        input  logic [31:0] addr,
        input  logic [31:0] mdata,
        input  logic [31:0] rdata,
        input  int          delay,
        output int          stalls,
        output logic [31:0] seen_sel,
        output logic [31:0] seen_bwdata,
        output logic [31:0] seen_wbdata,
        output logic        seen_err
    );
        int          size;
        int          base;
        int          w;
        int          exp_waits;
        bit          done;
        bit          timed;
        bit          misal;
        logic [31:0] exp_sel;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        longint      v;

        size        = access_bytes(op);
        stalls      = 0;
        seen_sel    = '0;
        seen_bwdata = '0;
        seen_wbdata = '0;
        seen_err    = 1'b0;
        ex_valid = 1'b1;
        ex_memop = op;
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = alu;
        ex_maddr = addr;
        ex_mdata = mdata;
        @(negedge clk);
        if (size == 0) begin
            checkOutput("pt_valid", wb_valid, 1);
            checkOutput("pt_wd", wb_wd, wd);
            checkOutput("pt_wreg", wb_wreg, wreg);
            checkOutput("pt_wdata", wb_wdata, alu);
            checkOutput("pt_stall", stallreq, 0);
            checkOutput("pt_req", bus.req, 0);
            seen_wbdata = wb_wdata;
        end else begin
            misal = (int'(addr[1:0]) % size) != 0;
            base  = int'(addr[1:0]) - (int'(addr[1:0]) % size);
`ifdef MEM_ALIGN_EXC_EN
            if (misal) begin
                checkOutput("mis_req", bus.req, 0);
                checkOutput("mis_stall", stallreq, 0);
                checkOutput("mis_valid", wb_valid, 1);
                checkOutput("mis_wreg", wb_wreg, 0);
                checkOutput("mis_err", bus_err, 1);
                seen_err = bus_err;
            end else
`endif
            begin
                ex_valid = 1'b0;
                exp_sel  = '0;
                exp_wd   = '0;
                for (int i = 0; i < 4; i++) begin
                    if (i >= base && i < base + size) exp_sel[i] = 1'b1;
                    exp_wd[8*i +: 8] = mdata[8*(i % size) +: 8];
                end
                checkOutput("req_up", bus.req, 1);
                checkOutput("req_we", bus.we, !op_loads(op));
                checkOutput("req_addr", bus.addr, {addr[31:2], 2'b00});
                checkOutput("req_sel", bus.sel, exp_sel);
                if (!op_loads(op)) checkOutput("req_wdata", bus.wdata, exp_wd);
                checkOutput("wait_valid", wb_valid, 0);
                seen_sel    = 32'(bus.sel);
                seen_bwdata = bus.wdata;

                w    = 0;
                done = 1'b0;
                bus.rdata = rdata;
                while (!done) begin
                    w++;
                    if (stallreq) stalls++;
                    bus.ack = (w == delay + 1);
                    done    = bus.ack || (w >= TMO);
                    @(negedge clk);
                    bus.ack = 1'b0;
                end

                timed     = (delay >= TMO);
                exp_waits = timed ? TMO : delay + 1;
                v = 0;
                for (int j = 0; j < size; j++)
                    v += longint'(rdata[8*(base+j) +: 8]) << (8*j);
                if (op_signed(op) && v >= (longint'(1) << (8*size - 1)))
                    v -= longint'(1) << (8*size);
                exp_ld = v[31:0];

                checkOutput("stall_cycles", stalls, exp_waits);
                checkOutput("ret_req", bus.req, 0);
                checkOutput("ret_stall", stallreq, 0);
                checkOutput("ret_valid", wb_valid, 1);
                checkOutput("ret_err", bus_err, timed);
                checkOutput("ret_wreg", wb_wreg, (op_loads(op) && !timed) ? wreg : 1'b0);
                if (!timed) checkOutput("ret_wd", wb_wd, wd);
                if (op_loads(op) && !timed) checkOutput("ret_ldata", wb_wdata, exp_ld);
                seen_wbdata = wb_wdata;
                seen_err    = bus_err;
            end
        end
        ex_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_valid", wb_valid, 0);
        checkOutput("idle_wreg", wb_wreg, 0);
        checkOutput("idle_err", bus_err, 0);
        checkOutput("idle_stall", stallreq, 0);
    endtask

    logic [3:0] op_tab [9] = '{MEM_OP_NONE, MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU,
                               MEM_OP_LW, MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};

    initial begin
        int          stalls;
        logic [31:0] s_sel;
        logic [31:0] s_bw;
        logic [31:0] s_wb;
        logic        s_err;

        ex_valid  = 1'b0;
        ex_wd     = '0;
        ex_wreg   = 1'b0;
        ex_wdata  = '0;
        ex_memop  = MEM_OP_NONE;
        ex_maddr  = '0;
        ex_mdata  = '0;
        bus.ack   = 1'b0;
        bus.rdata = '0;
        #2 rst = 1'b1;

        @(negedge clk);
        checkOutput("rst_req", bus.req, 0);
        checkOutput("rst_stall", stallreq, 0);
        checkOutput("rst_err", bus_err, 0);
        checkOutput("rst_valid", wb_valid, 0);
        checkOutput("rst_wd", wb_wd, 0);
        checkOutput("rst_wreg", wb_wreg, 0);
        checkOutput("rst_wdata", wb_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] pass-through");
        applyStimulus(MEM_OP_NONE, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 0,
                      stalls, s_sel, s_bw, s_wb, s_err);
        checkOutput("t1_wdata", s_wb, 32'h1234);

        $display("[TB] LB with 3 wait cycles");
        applyStimulus(MEM_OP_LB, 5'd3, 1'b1, 32'h0, 32'h103, 32'h0, 32'h8000_0000, 3,
                      stalls, s_sel, s_bw, s_wb, s_err);
        checkOutput("t2_stalls", stalls, 4);
        checkOutput("t2_sel", s_sel, 32'h8);
        checkOutput("t2_ldata", s_wb, 32'hFFFF_FF80);

        $display("[TB] SH replication");
        applyStimulus(MEM_OP_SH, 5'd4, 1'b1, 32'h0, 32'h202, 32'h0000_BEEF, 32'h0, 1,
                      stalls, s_sel, s_bw, s_wb, s_err);
        checkOutput("t3_sel", s_sel, 32'hC);
        checkOutput("t3_wdata", s_bw, 32'hBEEF_BEEF);

        $display("[TB] LW timeout and last-cycle ack");
        applyStimulus(MEM_OP_LW, 5'd6, 1'b1, 32'h0, 32'h300, 32'h0, 32'h1111_2222, 20,
                      stalls, s_sel, s_bw, s_wb, s_err);
        checkOutput("t4_to_err", s_err, 1);
        checkOutput("t4_to_stalls", stalls, 4);
        applyStimulus(MEM_OP_LW, 5'd6, 1'b1, 32'h0, 32'h300, 32'h0, 32'h1111_2222, 3,
                      stalls, s_sel, s_bw, s_wb, s_err);
        checkOutput("t4_ack_err", s_err, 0);
        checkOutput("t4_ack_data", s_wb, 32'h1111_2222);

        $display("[TB] reset during WAIT");
        ex_valid = 1'b1;
        ex_memop = MEM_OP_LW;
        ex_maddr = 32'h400;
        ex_wd    = 5'd7;
        ex_wreg  = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        checkOutput("t5_req_before", bus.req, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_req", bus.req, 0);
        checkOutput("t5_stall", stallreq, 0);
        checkOutput("t5_valid", wb_valid, 0);
        checkOutput("t5_wreg", wb_wreg, 0);
        checkOutput("t5_wd", wb_wd, 0);
        @(negedge clk);
        rst       = 1'b0;
        bus.ack   = 1'b1;
        bus.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.ack = 1'b0;
        checkOutput("t5_no_retire", wb_valid, 0);
        checkOutput("t5_no_req", bus.req, 0);
        checkOutput("t5_no_stall", stallreq, 0);

        $display("[TB] LH misaligned");
        applyStimulus(MEM_OP_LH, 5'd9, 1'b1, 32'h0, 32'h101, 32'h0, 32'h1234_F00D, 0,
                      stalls, s_sel, s_bw, s_wb, s_err);
`ifdef MEM_ALIGN_EXC_EN
        checkOutput("t6_err", s_err, 1);
`else
        checkOutput("t6_sel", s_sel, 32'h3);
        checkOutput("t6_ldata", s_wb, 32'hFFFF_F00D);
`endif

        $display("[TB] random instructions");
        for (int n = 0; n < 80; n++) begin
            applyStimulus(op_tab[$urandom_range(0, 8)], 5'($urandom), 1'($urandom),
                          $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 5),
                          stalls, s_sel, s_bw, s_wb, s_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
